// File: rtl/unpacker_stream.sv
// unpacker_stream: splits wide packet beats into narrow chunks
// with valid/ready flow control on both sides.
module unpacker_stream #(
    parameter int IN_BYTES  = 160,
    parameter int OUT_BYTES = 32,
    parameter int VBC_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic                   in_val,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [VBC_W-1:0]       in_vbc,
    input  logic [IN_BYTES*8-1:0]  in_data,
    output logic                   in_ready,
    output logic                   o_val,
    output logic                   o_sop,
    output logic                   o_eop,
    output logic [VBC_W-1:0]       o_vbc,
    output logic [OUT_BYTES*8-1:0] o_data,
    input  logic                   o_ready,
    output logic                   idle,
    output logic                   err
);

    localparam int IW      = IN_BYTES * 8;
    localparam int OW      = OUT_BYTES * 8;
    localparam int NCH_MAX = (IN_BYTES + OUT_BYTES - 1) / OUT_BYTES;
    localparam int CW      = $clog2(NCH_MAX + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    data_q, data_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic [VBC_W-1:0] vbc_q, vbc_d;
    logic [CW-1:0]    nch_q, nch_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             err_q, err_d;
    logic             live_q;

    logic             busy;
    logic             is_last;
    logic             legal;
    logic             in_acc;
    logic             out_acc;
    logic [CW-1:0]    in_nch;
    logic [VBC_W-1:0] vbc_c;
    logic [OW-1:0]    chunk;

    // Handshake qualifiers and the chunk count of the offered beat
    always_comb begin
        busy     = (state_q == BUSY);
        is_last  = (idx_q == nch_q - CW'(1));
        legal    = (in_vbc != '0) && (in_vbc <= VBC_W'(IN_BYTES));
        in_ready = live_q && (!busy || (is_last && o_ready));
        in_acc   = in_val && in_ready;
        out_acc  = busy && o_ready;
        in_nch   = CW'((int'(in_vbc) + OUT_BYTES - 1) / OUT_BYTES);
    end

    // Next-state: load on legal accept, else step or retire chunks
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        vbc_d   = vbc_q;
        nch_d   = nch_q;
        idx_d   = idx_q;
        err_d   = in_acc && !legal;
        if (in_acc && legal) begin
            state_d = BUSY;
            data_d  = in_data;
            sop_d   = in_sop;
            eop_d   = in_eop;
            vbc_d   = in_vbc;
            nch_d   = in_nch;
            idx_d   = '0;
        end else if (out_acc) begin
            if (is_last) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q + CW'(1);
            end
        end
    end

    // State registers; live_q holds in_ready low until the first edge
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            vbc_q   <= '0;
            nch_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            vbc_q   <= vbc_d;
            nch_q   <= nch_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    // Output chunk: select by index, zero bytes past the valid count
    always_comb begin
        if (!busy) begin
            vbc_c = '0;
        end else if (is_last) begin
            vbc_c = VBC_W'(int'(vbc_q) - (int'(nch_q) - 1) * OUT_BYTES);
        end else begin
            vbc_c = VBC_W'(OUT_BYTES);
        end
        chunk = OW'(data_q >> (int'(idx_q) * OW));
        for (int b = 0; b < OUT_BYTES; b++) begin
            if (b >= int'(vbc_c)) begin
                chunk[b*8 +: 8] = 8'h00;
            end
        end
        o_val  = busy;
        idle   = !busy;
        o_sop  = busy && sop_q && (idx_q == '0);
        o_eop  = busy && eop_q && is_last;
        o_vbc  = vbc_c;
        o_data = chunk;
        err    = err_q;
    end

endmodule

// File: tb/tb_unpacker_stream.sv
// tb_unpacker_stream: directed beats into two unpacker configurations,
// scoreboard queues checked by a negedge monitor.
module tb_unpacker_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_L;
    logic          in_val0, in_val1, in_sop, in_eop, o_ready;
    logic [7:0]    in_vbc;
    logic [1279:0] in_data;

    logic          in_ready0, o_val0, o_sop0, o_eop0, idle0, err0;
    logic [7:0]    o_vbc0;
    logic [255:0]  o_data0;
    logic          in_ready1, o_val1, o_sop1, o_eop1, idle1, err1;
    logic [6:0]    o_vbc1;
    logic [127:0]  o_data1;

    unpacker_stream dut0 (
        .clk(clk), .reset_L(reset_L),
        .in_val(in_val0), .in_sop(in_sop), .in_eop(in_eop),
        .in_vbc(in_vbc), .in_data(in_data), .in_ready(in_ready0),
        .o_val(o_val0), .o_sop(o_sop0), .o_eop(o_eop0),
        .o_vbc(o_vbc0), .o_data(o_data0), .o_ready(o_ready),
        .idle(idle0), .err(err0)
    );

    unpacker_stream #(.IN_BYTES(64), .OUT_BYTES(16), .VBC_W(7)) dut1 (
        .clk(clk), .reset_L(reset_L),
        .in_val(in_val1), .in_sop(in_sop), .in_eop(in_eop),
        .in_vbc(in_vbc[6:0]), .in_data(in_data[511:0]),
        .in_ready(in_ready1),
        .o_val(o_val1), .o_sop(o_sop1), .o_eop(o_eop1),
        .o_vbc(o_vbc1), .o_data(o_data1), .o_ready(o_ready),
        .idle(idle1), .err(err1)
    );

    typedef struct packed {
        logic [255:0] data;
        logic [7:0]   vbc;
        logic         sop;
        logic         eop;
        logic         last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   npop0 = 0;
    int   err_cnt0 = 0, err_cnt1 = 0;
    int   exp_err0 = 0, exp_err1 = 0;
    bit   mon_en = 1'b0;

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mon(int sel, logic ov, logic ir, logic os, logic oe,
                       logic [7:0] vb, logic [255:0] d);
        exp_t e;
        int   n;
        n = (sel != 0) ? q1.size() : q0.size();
        if (!ov) begin
            chk($sformatf("idle_ready%0d", sel), ir, 1);
            return;
        end
        if (n == 0) begin
            chk($sformatf("unexpected_chunk%0d", sel), ov, 0);
            return;
        end
        e = (sel != 0) ? q1[0] : q0[0];
        chk($sformatf("o_vbc%0d", sel), vb, e.vbc);
        chk($sformatf("o_sop%0d", sel), os, e.sop);
        chk($sformatf("o_eop%0d", sel), oe, e.eop);
        chk($sformatf("o_data%0d", sel), d, e.data);
        chk($sformatf("in_ready%0d", sel), ir, e.last && o_ready);
        if (o_ready) begin
            if (sel != 0) begin
                void'(q1.pop_front());
            end else begin
                void'(q0.pop_front());
                npop0++;
            end
        end
    endtask

    // Scoreboard monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (mon_en && reset_L) begin
            mon(0, o_val0, in_ready0, o_sop0, o_eop0, o_vbc0, {128'd0, o_data0});
            mon(1, o_val1, in_ready1, o_sop1, o_eop1, {1'b0, o_vbc1},
                {128'd0, o_data1});
            if (err0) err_cnt0++;
            if (err1) err_cnt1++;
        end
    end

    // Offer one beat; expected chunk sizes c0..c4 are given by hand
    task automatic send(int sel, int vbc, bit sop, bit eop, int seed,
                        int c0, int c1, int c2, int c3, int c4);
        int   ob;
        int   cs[5];
        int   nch;
        int   guard;
        logic rdy;
        exp_t e;
        ob = (sel != 0) ? 16 : 32;
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3; cs[4] = c4;
        for (int i = 0; i < 160; i++) begin
            in_data[i*8 +: 8] = {1'b1, 7'(seed * 29 + i * 5)};
        end
        in_vbc = 8'(vbc);
        in_sop = sop;
        in_eop = eop;
        nch = 0;
        for (int k = 0; k < 5; k++) if (cs[k] != 0) nch = k + 1;
        for (int k = 0; k < nch; k++) begin
            e.vbc  = 8'(cs[k]);
            e.data = '0;
            for (int j = 0; j < cs[k]; j++) begin
                e.data[j*8 +: 8] = in_data[(k*ob + j)*8 +: 8];
            end
            e.sop  = sop && (k == 0);
            e.eop  = eop && (k == nch - 1);
            e.last = (k == nch - 1);
            if (sel != 0) q1.push_back(e);
            else q0.push_back(e);
        end
        if (nch == 0) begin
            if (sel != 0) exp_err1++;
            else exp_err0++;
        end
        if (sel != 0) in_val1 = 1'b1;
        else in_val0 = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            rdy = (sel != 0) ? in_ready1 : in_ready0;
            guard++;
        end while (!rdy && guard < 200);
        if (!rdy) begin
            chk("accept_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        in_val0 = 1'b0;
        in_val1 = 1'b0;
        if (nch != 0) begin
            chk("latency_oval", (sel != 0) ? o_val1 : o_val0, 1);
        end else begin
            chk("err_pulse", (sel != 0) ? err1 : err0, 1);
            chk("illegal_no_out", (sel != 0) ? o_val1 : o_val0, 0);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 300) begin
            @(posedge clk);
            guard++;
        end
        #1;
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
    endtask

    initial begin
        int base;
        int guard;
        reset_L = 1'b0;
        in_val0 = 1'b0;
        in_val1 = 1'b0;
        in_sop  = 1'b0;
        in_eop  = 1'b0;
        in_vbc  = '0;
        in_data = '0;
        o_ready = 1'b1;
        #3;
        chk("rst_oval", o_val0, 0);
        chk("rst_idle", idle0, 1);
        chk("rst_ready", in_ready0, 0);
        chk("rst_vbc", o_vbc0, 0);
        chk("rst_data", o_data0, 0);
        chk("rst_err", err0, 0);
        #9;
        reset_L = 1'b1;
        #1;
        chk("ready_before_edge", in_ready0, 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", in_ready0, 1);
        mon_en = 1'b1;

        send(0, 160, 1, 1, 1, 32, 32, 32, 32, 32);
        drain();

        send(0, 70, 1, 0, 2, 32, 32, 6, 0, 0);
        send(0, 20, 0, 1, 3, 20, 0, 0, 0, 0);
        drain();

        send(0, 100, 1, 1, 4, 32, 32, 32, 4, 0);
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        o_ready = 1'b1;
        drain();

        send(0, 0, 1, 1, 5, 0, 0, 0, 0, 0);
        send(0, 200, 1, 1, 6, 0, 0, 0, 0, 0);
        send(0, 33, 1, 1, 7, 32, 1, 0, 0, 0);
        drain();

        base = npop0;
        send(0, 160, 1, 1, 8, 32, 32, 32, 32, 32);
        guard = 0;
        while (npop0 < base + 2 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        chk("reach_chunk2", npop0 - base, 2);
        #1;
        mon_en = 1'b0;
        #2;
        reset_L = 1'b0;
        #1;
        chk("arst_oval", o_val0, 0);
        chk("arst_idle", idle0, 1);
        chk("arst_ready", in_ready0, 0);
        chk("arst_data", o_data0, 0);
        q0.delete();
        @(negedge clk);
        #2;
        reset_L = 1'b1;
        #1;
        chk("arst_ready_hold", in_ready0, 0);
        @(posedge clk);
        #1;
        chk("arst_ready_rise", in_ready0, 1);
        chk("arst_no_out", o_val0, 0);
        mon_en = 1'b1;
        send(0, 10, 1, 1, 9, 10, 0, 0, 0, 0);
        drain();

        send(1, 64, 1, 1, 10, 16, 16, 16, 16, 0);
        send(1, 17, 1, 1, 11, 16, 1, 0, 0, 0);
        drain();

        repeat (2) @(posedge clk);
        #1;
        chk("err_count0", err_cnt0, exp_err0);
        chk("err_count1", err_cnt1, exp_err1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
